// File: rtl/mp_addsub_pkg.sv
// Shared types and defaults for the sequential multi-precision adder/subtractor.
package mp_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N = 16;
  localparam int DEF_W = 64;

  // Width of the slice index; never narrower than one bit.
  function automatic int slice_idx_w(input int k);
    if (k <= 1) return 1;
    return $clog2(k);
  endfunction

endpackage

// File: rtl/cla_unit.sv
// N-bit carry-lookahead unit: every carry c[i] is formed directly from p/g/cin.
// c[0] is the carry-in, c[N] the carry-out; pg/gg are the group propagate/generate.
module cla_unit #(
  parameter int N = 16
) (
  input  logic [N-1:0] p,
  input  logic [N-1:0] g,
  input  logic         cin,
  output logic [N:0]   c,
  output logic         cout,
  output logic         pg,
  output logic         gg
);

  logic gacc;
  logic pacc;

  always_comb begin
    c    = '0;
    c[0] = cin;
    gg   = 1'b0;
    gacc = 1'b0;
    pacc = 1'b0;
    for (int i = 0; i < N; i++) begin
      gacc = g[i];
      pacc = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        gacc = gacc | (pacc & g[j]);
        pacc = pacc & p[j];
      end
      c[i+1] = gacc | (pacc & cin);
      if (i == N - 1) gg = gacc;
    end
  end

  assign cout = c[N];
  assign pg   = &p;

endmodule

// File: rtl/mp_addsub_seq.sv
// Multi-cycle W-bit add/subtract, one N-bit slice per cycle through a single cla_unit.
// Optional zero-result flag output enabled by defining MPADD_ZERO_FLAG_EN.
module mp_addsub_seq
  import mp_addsub_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
`ifdef MPADD_ZERO_FLAG_EN
  ,
  output logic         zero
`endif
);

  localparam int K  = W / N;
  localparam int KW = slice_idx_w(K);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  if ((W % N) != 0 || W < N) begin : g_bad_width
    $error("mp_addsub_seq: W (%0d) must be a positive multiple of N (%0d)", W, N);
  end

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic                carry_q, carry_d;
  logic [K-1:0][N-1:0] a_q, b_q, sum_q;
  logic                cout_q, ovf_q;
  logic                load, run, last;

  logic [N-1:0]        p_s, g_s, slice_sum;
  logic [N:0]          c_s;
  logic                cla_cout, cla_pg, cla_gg;
  logic                unused_cla;

  assign p_s       = a_q[k_q] ^ b_q[k_q];
  assign g_s       = a_q[k_q] & b_q[k_q];
  // c_s[0] is the slice carry-in, so c_s[N-1:0] is exactly the per-bit carry vector.
  assign slice_sum = p_s ^ c_s[N-1:0];
  assign last      = (k_q == K_LAST);

  cla_unit #(.N(N)) u_cla (
    .p    (p_s),
    .g    (g_s),
    .cin  (carry_q),
    .c    (c_s),
    .cout (cla_cout),
    .pg   (cla_pg),
    .gg   (cla_gg)
  );

  assign unused_cla = &{1'b0, cla_pg, cla_gg};

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    load    = 1'b0;
    run     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          carry_d = cin ^ sub;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        run     = 1'b1;
        carry_d = cla_cout;
        if (last) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      if (run) begin
        sum_q[k_q] <= slice_sum;
        if (last) begin
          cout_q <= cla_cout;
          ovf_q  <= c_s[N] ^ c_s[N-1];
        end
      end
    end
  end

  // Operand staging: B is stored pre-inverted for subtraction.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q <= a;
      b_q <= sub ? ~b : b;
    end
  end

`ifdef MPADD_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (load) begin
      zero_q <= 1'b1;
    end else if (run) begin
      zero_q <= zero_q & (slice_sum == '0);
    end
  end

  assign zero = zero_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Randomized and directed bench for mp_addsub_seq against a plain-arithmetic model.
module tb_mp_addsub_seq;

  localparam int N = 16;
  localparam int W = 64;
  localparam int K = W / N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         sub, cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf;
`ifdef MPADD_ZERO_FLAG_EN
  logic         zero;
`endif

  int n_vec = 0;
  int n_err = 0;

  mp_addsub_seq #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef MPADD_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from the arithmetic definition of add / subtract-with-borrow.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic ms, input logic mc);
    logic [W:0]   wide;
    logic [W-1:0] s;
    logic         co, of;
    if (!ms) begin
      wide = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
      s    = wide[W-1:0];
      co   = wide[W];
      of   = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
    end else begin
      s  = ma - mb - {{(W-1){1'b0}}, mc};
      co = ({1'b0, ma} >= ({1'b0, mb} + {{W{1'b0}}, mc}));
      of = (ma[W-1] != mb[W-1]) && (s[W-1] != ma[W-1]);
    end
    return {of, co, s};
  endfunction

  task automatic wait_ready(input string tag);
    int cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (!in_ready) check({tag, " ready_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    if (!out_valid) check({tag, " valid_timeout"}, 0, 1);
  endtask

  task automatic check_result(input string tag, input logic [W+1:0] e);
    check({tag, " sum"},  sum,  e[W-1:0]);
    check({tag, " cout"}, cout, e[W]);
    check({tag, " ovf"},  ovf,  e[W+1]);
`ifdef MPADD_ZERO_FLAG_EN
    check({tag, " zero"}, zero, (e[W-1:0] == '0));
`endif
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                        input logic tc, input int stall, input string tag);
    logic [W+1:0] e;
    int           cyc;
    e = model(ta, tb_, ts, tc);
    wait_ready(tag);
    a = ta; b = tb_; sub = ts; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    sub = 1'($urandom); cin = 1'($urandom);
    wait_valid(tag, cyc);
    check({tag, " latency"}, cyc, K);
    for (int i = 0; i < stall; i++) begin
      check({tag, " hold_sum"}, sum, e[W-1:0]);
      check({tag, " hold_inrdy"}, in_ready, 1'b0);
      @(posedge clk); #1;
    end
    check_result(tag, e);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " vld_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W+1:0] e;
    int           cyc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready",  in_ready,  1'b1);
    check("rst out_valid", out_valid, 1'b0);
    check("rst sum",       sum,       '0);
    check("rst cout",      cout,      1'b0);
    check("rst ovf",       ovf,       1'b0);
`ifdef MPADD_ZERO_FLAG_EN
    check("rst zero",      zero,      1'b0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 0, "carry01");
    check("carry01 ref", sum, 64'h0000_0000_0001_0000);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1, "ripple");
    check("ripple cout ref", cout, 1'b1);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, "sovf");
    check("sovf ref", {ovf, sum}, {1'b1, 64'h8000_0000_0000_0000});
    run_op(64'd5, 64'd7, 1'b1, 1'b0, 0, "sub0");
    check("sub0 ref", {cout, sum}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    run_op(64'd5, 64'd7, 1'b1, 1'b1, 0, "sub1");
    check("sub1 ref", {cout, sum}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});

    // Backpressure: second request pending throughout the DONE dwell.
    wait_ready("bp");
    a = 64'd100; b = 64'd23; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 64'hDEAD_BEEF_0000_0001; b = 64'h0000_0000_1111_2222; sub = 1'b1; cin = 1'b0;
    wait_valid("bp", cyc);
    check("bp latency", cyc, K);
    for (int i = 0; i < 5; i++) begin
      check("bp hold_sum",   sum,       64'd123);
      check("bp hold_inrdy", in_ready,  1'b0);
      check("bp hold_vld",   out_valid, 1'b1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp no_same_cycle_accept", in_ready, 1'b1);
    check("bp vld_drop", out_valid, 1'b0);
    @(posedge clk); #1;
    check("bp second_accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_valid("bp2", cyc);
    check_result("bp2", model(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_1111_2222, 1'b1, 1'b0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset asserted while slice 2 is in flight.
    wait_ready("mrst");
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0101_0101_0101_0101; sub = 1'b0; cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mrst out_valid", out_valid, 1'b0);
    check("mrst in_ready",  in_ready,  1'b1);
    check("mrst sum",       sum,       '0);
    check("mrst cout",      cout,      1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(64'd3, 64'd4, 1'b0, 1'b0, 0, "post_rst");
    check("post_rst ref", sum, 64'd7);

    for (int n = 0; n < 1000; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: ra = '1;
        1: rb = '1;
        2: ra = {1'b0, {(W-1){1'b1}}};
        3: rb = {1'b1, {(W-1){1'b0}}};
        4: rb = ra;
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3),
             $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t limit %0t", $time, 3_000_000);
    $fatal(1);
  end

endmodule

// File: doc/mp_addsub_seq.md
Name: mp_addsub_seq

Overview:
- Multi-cycle, multi-precision adder/subtractor on the consumer side of cla_unit.
- Each cycle, one N-bit slice of the W-bit operands is fed through a single cla_unit as p/g.
- The sum slice is formed from the returned carries, and cla_unit cout is registered as the carry into the next slice.
- Valid/ready handshake on both ends; sits between operand staging and result writeback in the wide-arithmetic datapath.

Parameters:
- N, 16, slice width; the width of the cla_unit instance.
- W, 64, operand width; must be a multiple of N (elaboration $error otherwise).
- K (localparam), W/N, number of slices and the cycle count of one operation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  W  operand A.
- b  in  W  operand B.
- sub  in  1  1 = A−B−(borrow), 0 = A+B+cin.
- cin  in  1  carry-in (add) / borrow-in (sub).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  W  result.
- cout  out  1  final carry; for sub, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE, slice index k = 0, carry register = 0.
  - sum = 0, cout = 0, ovf = 0, out_valid = 0.
  - in_ready = 1 (decoded combinationally from state == IDLE).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On in_valid & in_ready, register a_r = a and b_r = sub ? ~b : b.
  - Load carry = cin ^ sub, set k = 0, go to RUN.
  - in_valid without acceptance has no effect.
- RUN, slice k, each cycle:
  - p = a_r[kN+:N] ^ b_r[kN+:N], g = a_r[kN+:N] & b_r[kN+:N].
  - cla_unit.cin = carry.
  - sum_r[kN+:N] = p ^ {c[N-1:1], carry}.
  - carry <= cla_unit.cout, k <= k+1.
  - When k == K−1:
    - cout <= cla_unit.cout.
    - ovf <= c[N] ^ c[N-1] of that slice (the carry into MSB is c[N-1]; for N=1 it is the slice carry-in).
    - go to DONE.
- Unused cla_unit outputs: PG/GG are ignored.
- Latency: accept at edge T; out_valid rises at edge T+K (K=4 by default); the result is valid for the whole DONE dwell.
- DONE:
  - out_valid = 1; sum/cout/ovf held stable while out_ready = 0.
  - On out_ready, next state is IDLE, out_valid drops at that edge, and in_ready = 1 the following cycle.
  - There is no same-cycle release+accept, so the throughput is one operation per K+2 cycles.
- Inputs a/b/sub/cin are sampled only at acceptance; changes during RUN/DONE are ignored.
- Wrap-around: all arithmetic is modulo 2^W; the carry out of slice K−1 only goes to cout.
- Reset mid-RUN or mid-DONE: immediately abort, discard partial sum, and return all outputs to their reset values; no result is emitted.

Optional Feature:
- Macro MPADD_ZERO_FLAG_EN.
- When defined:
  - Extra output port zero (1 bit).
  - A zero_acc register is set to 1 on accept and ANDed with (slice sum == 0) each RUN cycle.
  - zero is valid with out_valid and resets to 0.
- When undefined: no port, no register; all other behaviour is identical.

Decomposition:
- Package mp_addsub_pkg holds:
  - the state enum typedef (IDLE/RUN/DONE);
  - default N/W localparams;
  - a slice-index width function ($clog2(K), minimum 1).
- Sub-module: one instance of the existing cla_unit #(.N(N)).
- Everything else (FSM, operand/sum registers, carry register) stays in mp_addsub_seq.

Test Plan:
- Add, carry across slice 0→1: a=64'h0000_0000_0000_FFFF, b=1, sub=0, cin=0 → sum=64'h0000_0000_0001_0000, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- Full ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=0, cout=1, ovf=0 (zero=1 when MPADD_ZERO_FLAG_EN).
- Signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1 → sum=64'h8000_0000_0000_0000, cout=0, ovf=1.
- Subtract with borrow: a=5, b=7, sub=1, cin=0 → sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Same with cin=1 → sum=64'hFFFF_FFFF_FFFF_FFFD.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with new operands → sum stable, in_ready=0, second op not accepted until one cycle after out_ready.
- Reset mid-RUN: drop rst_n during slice 2 → out_valid=0, in_ready=1, sum=0 asynchronously. After release, a fresh op (a=3, b=4) yields sum=7.
- Random: 1000 ops with random a/b/sub/cin and random out_ready stalls, checked against {cout,sum} = a + (sub?~b:b) + (cin^sub) and ovf from the operand/result sign bits.
